seq_pattern_tx: RTL and testbench

SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

---
 rtl/seq_pattern_tx.sv | 98 +++++++++
 tb/tb_seq_pattern_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - repeated serial pattern transmitter, MSB first
// Sends (repeat_n+1) frames of pattern with one idle-level gap cycle between frames.
module seq_pattern_tx #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] frames_left, frames_left_nxt;
  logic [WIDTH-1:0] shadow_pat, shadow_pat_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= IDX_MAX;
      frames_left <= '0;
      shadow_pat  <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      frames_left <= frames_left_nxt;
      shadow_pat  <= shadow_pat_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    frames_left_nxt = frames_left;
    shadow_pat_nxt  = shadow_pat;
    case (state)
      IDLE: begin
        if (start) begin
          shadow_pat_nxt  = pattern;
          frames_left_nxt = repeat_n;
          idx_nxt         = IDX_MAX;
          state_nxt       = SHIFT;
        end
      end
      SHIFT: begin
        // idx parks at 0 on the last bit; GAP reloads it for the next frame
        if (idx == '0) begin
          if (frames_left == '0) begin
            state_nxt = DONE;
          end else begin
            frames_left_nxt = frames_left - CNT_W'(1);
            state_nxt       = GAP;
          end
        end else begin
          idx_nxt = idx - IDX_W'(1);
        end
      end
      GAP: begin
        idx_nxt   = IDX_MAX;
        state_nxt = SHIFT;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    out       = 1'b1;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    if (state == SHIFT) begin
      out       = shadow_pat[idx];
      out_valid = 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb/tb_seq_pattern_tx.sv - self-checking bench for seq_pattern_tx
// Expected per-cycle {out,out_valid,busy,done} streams come from a frame-level queue model.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [3:0] repeat_n = 4'h0;
  logic       out, out_valid, busy, done;

  int n_checks = 0;
  int n_fail = 0;
  logic [3:0] exp_q[$];

  localparam logic [3:0] V_IDLE = 4'b1000;
  localparam logic [3:0] V_GAP  = 4'b1010;
  localparam logic [3:0] V_DONE = 4'b1011;

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .repeat_n(repeat_n),
    .out(out), .out_valid(out_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transmission: frames MSB first, a gap between frames, DONE, then an IDLE cycle.
  function automatic void build(input logic [7:0] pat, input int rn);
    for (int f = 0; f <= rn; f++) begin
      for (int b = 7; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0});
      if (f < rn) exp_q.push_back(V_GAP);
    end
    exp_q.push_back(V_DONE);
    exp_q.push_back(V_IDLE);
  endfunction

  task automatic start_tx(input logic [7:0] pat, input logic [3:0] rn, input bit hold);
    pattern  = pat;
    repeat_n = rn;
    start    = 1'b1;
    step();
    if (!hold) start = 1'b0;
  endtask

  task automatic play(input string name, input bit noise, input int poke_at,
                      input int exp_valid, input int exp_gaps, input int exp_dones);
    int last_done = 0;
    int nv = 0, ng = 0, nd = 0;
    logic [3:0] obs;
    foreach (exp_q[i]) if (exp_q[i] == V_DONE) last_done = i;
    foreach (exp_q[i]) begin
      obs = {out, out_valid, busy, done};
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %b expected %b", name, i, obs, exp_q[i]);
      end
      if (out_valid) nv++;
      if (busy && !out_valid && !done) ng++;
      if (done) nd++;
      if (noise && i < last_done) begin
        start    = 1'($urandom);
        pattern  = 8'($urandom);
        repeat_n = 4'($urandom);
      end
      if (i == poke_at) begin
        start   = 1'b1;
        pattern = 8'hFF;
      end else if (i == poke_at + 1) begin
        start = 1'b0;
      end
      if (i >= last_done) start = 1'b0;
      if (i < exp_q.size() - 1) step();
    end
    n_checks++;
    if (nv != exp_valid || ng != exp_gaps || nd != exp_dones) begin
      n_fail++;
      $display("FAIL %s counts: got valid=%0d gap=%0d done=%0d expected valid=%0d gap=%0d done=%0d",
               name, nv, ng, nd, exp_valid, exp_gaps, exp_dones);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      n_checks++;
      if ({out, out_valid, busy, done} !== V_IDLE) begin
        n_fail++;
        $display("FAIL reset_hold: got %b expected %b", {out, out_valid, busy, done}, V_IDLE);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_single();
    build(8'h33, 0);
    start_tx(8'h33, 4'h0, 1'b0);
    play("single_33", 1'b0, -10, 8, 0, 1);
  endtask

  task automatic test_repeat();
    build(8'hA5, 2);
    start_tx(8'hA5, 4'h2, 1'b0);
    play("repeat_a5", 1'b0, -10, 24, 2, 1);
  endtask

  task automatic test_ignore_start();
    build(8'h33, 0);
    start_tx(8'h33, 4'h0, 1'b0);
    play("ignore_start", 1'b0, 2, 8, 0, 1);
    step();
    n_checks++;
    if ({out, out_valid, busy, done} !== V_IDLE) begin
      n_fail++;
      $display("FAIL ignore_start_idle: got %b expected %b", {out, out_valid, busy, done}, V_IDLE);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] obs;
    build(8'hC3, 1);
    start_tx(8'hC3, 4'h1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      obs = {out, out_valid, busy, done};
      n_checks++;
      if (obs !== exp_q[i]) begin
        n_fail++;
        $display("FAIL midrst_pre cycle %0d: got %b expected %b", i, obs, exp_q[i]);
      end
      if (i < 3) step();
    end
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({out, out_valid, busy, done} !== V_IDLE) begin
      n_fail++;
      $display("FAIL midrst_async: got %b expected %b", {out, out_valid, busy, done}, V_IDLE);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_hold: got done=%b busy=%b expected 0 0", done, busy);
      end
    end
    rst = 1'b0;
    build(8'h96, 0);
    start_tx(8'h96, 4'h0, 1'b0);
    play("after_reset", 1'b0, -10, 8, 0, 1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) build(8'h6D, 0);
    start_tx(8'h6D, 4'h0, 1'b1);
    play("back_to_back", 1'b0, -10, 24, 0, 3);
  endtask

  task automatic test_max_repeat();
    build(8'h5A, 15);
    start_tx(8'h5A, 4'hF, 1'b0);
    play("max_repeat", 1'b0, -10, 128, 15, 1);
  endtask

  task automatic test_random();
    logic [7:0] p;
    logic [3:0] r;
    for (int t = 0; t < 8; t++) begin
      p = 8'($urandom);
      r = 4'($urandom_range(0, 4));
      build(p, int'(r));
      start_tx(p, r, 1'b0);
      play("random", 1'b1, -10, (int'(r) + 1) * 8, int'(r), 1);
    end
  endtask

  initial begin
    #1;
    n_checks++;
    if ({out, out_valid, busy, done} !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected %b", {out, out_valid, busy, done}, V_IDLE);
    end
    test_reset();
    test_single();
    test_repeat();
    test_ignore_start();
    test_reset_midframe();
    test_back_to_back();
    test_max_repeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
